unidad_de_control_alu_md: RTL and testbench
===========================================

# unidad_de_control_alu_md

ALU control unit for the MIPS datapath, parametrised in data width, extended with an iterative multiply/divide sequencer and HI/LO registers. It decodes `alu_op`/`func_field` into the 4-bit ALU code combinationally. It also executes MULT/MULTU/DIV/DIVU over WIDTH+1 cycles and serves MFHI/MFLO/MTHI/MTLO. A `stall` output holds the pipeline while a HI/LO consumer waits on a busy sequencer.

## Interface
- `WIDTH`, 32: operand/HI/LO width, even, ≥4.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `alu_op`  in  3: main-control ALU operation class.
- `func_field`  in  6: R-type function field.
- `instr_valid`  in  1: the current instruction is in execute.
- `operand_a`, `operand_b`  in  WIDTH: rs/rt values.
- `alu_code`  out  4: ALU operation (combinational).
- `illegal`  out  1: undefined func under `alu_op`=010.
- `md_result`  out  WIDTH: HI for MFHI, LO for MFLO, otherwise 0.
- `md_result_sel`  out  1: writeback takes `md_result` instead of the ALU result.
- `busy`  out  1: sequencer running.
- `stall`  out  1: hold the pipeline this cycle.

## Operation
- `alu_op` decode:
  - 000→0010, 001→0110, 100→0111, 101→0000, 011→0001.
  - 010 decodes func: ADD 100000→0010, SUB 100010→0110, AND 100100→0000, OR 100101→0001, NOR 100111→1100, SLT 101010→0111.
  - HI/LO funcs MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011 → alu_code 0000, illegal=0.
  - Any other func → 0000, illegal=1. Undefined `alu_op` → 0000, illegal=0.
  - No X outputs.
- md-op = `instr_valid` & `alu_op`=010 & func ∈ HI/LO set.
- FSM:
  - IDLE → RUN on an accepted MULT*/DIV*. On that edge, latch magnitudes (signed ops only), sign flags and the divide-by-zero flag; clear the iteration counter (width clog2(WIDTH)+1).
  - RUN: one iteration per edge. Multiply is shift-add (2·WIDTH product). Divide is restoring (1 quotient bit per edge). RUN → FIX after WIDTH iterations.
  - FIX: apply signs and write HI/LO, then → IDLE.
- Arithmetic rules:
  - Signed multiply: product negated if signs differ. HI = upper WIDTH bits, LO = lower WIDTH bits.
  - Signed divide: quotient (LO) negated if signs differ; remainder (HI) takes the dividend's sign.
  - Divide by zero (signed or unsigned): HI = original `operand_a`, LO = all ones, no sign fix, normal latency.
- MTHI/MTLO: when accepted, write `operand_a` into HI/LO at the edge.
- MFHI/MFLO: `md_result` and `md_result_sel` driven combinationally from the current HI/LO.
- Acceptance: an md-op is accepted only when `busy`=0.
- `stall` = md-op & `busy`, combinational. A stalled instruction is held by the pipeline and re-presented.
- Non-md instructions never stall and run while `busy`=1.

## Timing
- Reset (async assert, synchronous release): state IDLE, HI=LO=0, counter 0, `busy`=0, `stall`=0, `md_result`=0, `md_result_sel`=0.
- Reset mid-operation aborts the operation; HI/LO read 0.
- Start accepted at edge E:
  - `busy`=1 from E through edge E+WIDTH+1 (WIDTH+1 cycles, 33 at WIDTH=32).
  - HI/LO are updated at edge E+WIDTH+1.
  - An MFHI/MFLO presented in the cycle after `busy` falls reads the new value.
- HI/LO hold their values during RUN/FIX; an MFHI in the start cycle itself reads the old value.
- Any MFHI/MFLO/MTHI/MTLO/MULT*/DIV* presented while `busy`=1 stalls and is not accepted.

## Structure
- Shared package `alu_ctrl_pkg`:
  - alu_code constants (ADD, SUB, AND, OR, NOR, SLT);
  - func-code constants;
  - alu_op class constants;
  - FSM state encoding (IDLE, RUN, FIX).
- Sub-module `unidad_de_control_alu_dec`: purely combinational; outputs `alu_code`, `illegal`, and md-op class flags (is_mul, is_div, is_signed, is_mfhi/mflo/mthi/mtlo).
- The top level holds the sequencer, HI/LO registers and stall logic.

## Test plan
(All scenarios at WIDTH=32.)
- Decode sweep:
  - `alu_op`=010, func 100111 → 1100.
  - `alu_op`=101 → 0000.
  - func 111111 → 0000, illegal=1.
  - `alu_op`=111 → 0000, illegal=0.
- MULT 0xFFFFFFFD × 7 → after 33 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU 0xFFFFFFFF × 2 → HI=1, LO=0xFFFFFFFE.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 0 → HI=7, LO=0xFFFFFFFF.
- MULT followed immediately by MFLO:
  - `stall`=1 for 33 cycles;
  - then `md_result`=product LO, `md_result_sel`=1;
  - an ADD during `busy` gives alu_code 0010 and `stall`=0.
- MTHI 0x12345678 then MFHI → `md_result`=0x12345678. A second MULT while `busy` → `stall`=1 and the operand is not latched.
- MULT 5×5, `rst_n` low after 10 iterations → `busy`=0 immediately; MFHI/MFLO return 0; a new MULT then completes normally.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control unit and its multiply/divide sequencer:
// ALU operation codes, R-type function codes, main-control alu_op classes and
// the sequencer state encoding.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_RTYPE = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_SLT   = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } md_state_t;

endpackage

// File: rtl/unidad_de_control_alu_dec.sv
// Combinational decoder: alu_op/func_field -> 4-bit ALU code, illegal flag and
// HI/LO operation class flags (flags only asserted for alu_op = R-type).
// Ports: alu_op, func_field in; alu_code, illegal, is_mul, is_div, is_signed,
// is_mfhi, is_mflo, is_mthi, is_mtlo out.
module unidad_de_control_alu_dec
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [5:0] func_field,
  output logic [3:0] alu_code,
  output logic       illegal,
  output logic       is_mul,
  output logic       is_div,
  output logic       is_signed,
  output logic       is_mfhi,
  output logic       is_mflo,
  output logic       is_mthi,
  output logic       is_mtlo
);

  always_comb begin
    alu_code  = ALU_AND;
    illegal   = 1'b0;
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    is_mfhi   = 1'b0;
    is_mflo   = 1'b0;
    is_mthi   = 1'b0;
    is_mtlo   = 1'b0;
    case (alu_op)
      OP_ADD: alu_code = ALU_ADD;
      OP_SUB: alu_code = ALU_SUB;
      OP_SLT: alu_code = ALU_SLT;
      OP_AND: alu_code = ALU_AND;
      OP_OR:  alu_code = ALU_OR;
      OP_RTYPE: begin
        case (func_field)
          FN_ADD:   alu_code = ALU_ADD;
          FN_SUB:   alu_code = ALU_SUB;
          FN_AND:   alu_code = ALU_AND;
          FN_OR:    alu_code = ALU_OR;
          FN_NOR:   alu_code = ALU_NOR;
          FN_SLT:   alu_code = ALU_SLT;
          FN_MFHI:  is_mfhi = 1'b1;
          FN_MTHI:  is_mthi = 1'b1;
          FN_MFLO:  is_mflo = 1'b1;
          FN_MTLO:  is_mtlo = 1'b1;
          FN_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
          FN_MULTU: is_mul = 1'b1;
          FN_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
          FN_DIVU:  is_div = 1'b1;
          default:  illegal = 1'b1;
        endcase
      end
      default: alu_code = ALU_AND;
    endcase
  end

endmodule

// File: rtl/unidad_de_control_alu_md.sv
// ALU control unit with iterative multiply/divide sequencer and HI/LO registers.
// Ports: clk, rst_n; alu_op, func_field, instr_valid, operand_a, operand_b in;
// alu_code, illegal (decode), md_result, md_result_sel (MFHI/MFLO writeback),
// busy (sequencer running), stall (HI/LO op waiting on busy sequencer) out.
// The sequencer works on magnitudes and fixes signs in a final FIX cycle.
module unidad_de_control_alu_md
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       func_field,
  input  logic             instr_valid,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [3:0]       alu_code,
  output logic             illegal,
  output logic [WIDTH-1:0] md_result,
  output logic             md_result_sel,
  output logic             busy,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic is_mul, is_div, is_signed, is_mfhi, is_mflo, is_mthi, is_mtlo;

  unidad_de_control_alu_dec u_dec (
    .alu_op     (alu_op),
    .func_field (func_field),
    .alu_code   (alu_code),
    .illegal    (illegal),
    .is_mul     (is_mul),
    .is_div     (is_div),
    .is_signed  (is_signed),
    .is_mfhi    (is_mfhi),
    .is_mflo    (is_mflo),
    .is_mthi    (is_mthi),
    .is_mtlo    (is_mtlo)
  );

  md_state_t        state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  // acc_hi: product upper half / remainder; acc_lo: multiplier / dividend->quotient
  logic [WIDTH-1:0] acc_hi, acc_lo, operand_r;
  logic             op_div, neg_res, rem_neg;

  logic md_op, accept, start;
  assign md_op  = instr_valid & (is_mul | is_div | is_mfhi | is_mflo | is_mthi | is_mtlo);
  assign busy   = (state != ST_IDLE);
  assign stall  = md_op & busy;
  assign accept = md_op & ~busy;
  assign start  = accept & (is_mul | is_div);

  logic             sign_a, sign_b, div_zero;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign sign_a   = is_signed & operand_a[WIDTH-1];
  assign sign_b   = is_signed & operand_b[WIDTH-1];
  assign div_zero = is_div & (operand_b == '0);
  // Divide-by-zero keeps the raw dividend so the remainder comes out as operand_a.
  assign mag_a    = (sign_a & ~div_zero) ? (~operand_a + ONE_W) : operand_a;
  assign mag_b    = sign_b ? (~operand_b + ONE_W) : operand_b;

  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic               div_ok;
  logic [2*WIDTH-1:0] prod, prod_neg;
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_r} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, operand_r};
  assign div_ok    = ~div_trial[WIDTH];
  assign prod      = {acc_hi, acc_lo};
  assign prod_neg  = ~prod + ONE_2W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      operand_r <= '0;
      op_div    <= 1'b0;
      neg_res   <= 1'b0;
      rem_neg   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept & is_mthi) hi_reg <= operand_a;
          if (accept & is_mtlo) lo_reg <= operand_a;
          if (start) begin
            state     <= ST_RUN;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= is_div ? mag_a : mag_b;
            operand_r <= is_div ? mag_b : mag_a;
            op_div    <= is_div;
            neg_res   <= (sign_a ^ sign_b) & ~div_zero;
            rem_neg   <= is_div & sign_a & ~div_zero;
          end
        end
        ST_RUN: begin
          if (op_div) begin
            acc_hi <= div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          if (op_div) begin
            lo_reg <= neg_res ? (~acc_lo + ONE_W) : acc_lo;
            hi_reg <= rem_neg ? (~acc_hi + ONE_W) : acc_hi;
          end else begin
            {hi_reg, lo_reg} <= neg_res ? prod_neg : prod;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    md_result     = '0;
    md_result_sel = 1'b0;
    if (instr_valid & ~busy & (is_mfhi | is_mflo)) begin
      md_result_sel = 1'b1;
      md_result     = is_mfhi ? hi_reg : lo_reg;
    end
  end

endmodule

// File: tb/tb_unidad_de_control_alu_md.sv
module tb_unidad_de_control_alu_md;

  logic        clk;
  logic        rst_n;
  logic [2:0]  alu_op;
  logic [5:0]  func_field;
  logic        instr_valid;
  logic [31:0] operand_a, operand_b;
  logic [3:0]  alu_code;
  logic        illegal;
  logic [31:0] md_result;
  logic        md_result_sel;
  logic        busy;
  logic        stall;

  int n_cmp = 0;
  int n_err = 0;

  unidad_de_control_alu_md #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_op        (alu_op),
    .func_field    (func_field),
    .instr_valid   (instr_valid),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .alu_code      (alu_code),
    .illegal       (illegal),
    .md_result     (md_result),
    .md_result_sel (md_result_sel),
    .busy          (busy),
    .stall         (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [5:0] fn;
    logic [3:0] exp_code;
    logic       exp_ill;
  } dec_vec_t;

  dec_vec_t dec_tab[17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    instr_valid = 1'b0;
    alu_op      = 3'b000;
    func_field  = 6'b000000;
    operand_a   = '0;
    operand_b   = '0;
  endtask

  task automatic present(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    instr_valid = 1'b1;
    alu_op      = 3'b010;
    func_field  = fn;
    operand_a   = a;
    operand_b   = b;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    @(negedge clk);
    present(6'b010000, 32'h0, 32'h0);
    #1;
    chk({tag, " hi"}, {32'h0, md_result}, {32'h0, ehi});
    chk({tag, " hi_sel"}, {63'h0, md_result_sel}, 64'h1);
    func_field = 6'b010010;
    #1;
    chk({tag, " lo"}, {32'h0, md_result}, {32'h0, elo});
    idle_inputs();
  endtask

  // present for one cycle, return #1 after the accepting edge with inputs idle
  task automatic start_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    present(fn, a, b);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_md(input string tag, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    start_md(fn, a, b);
    chk({tag, " busy_start"}, {63'h0, busy}, 64'h1);
    wait_busy(n);
    chk({tag, " busy_cycles"}, 64'(n), 64'd33);
    read_hilo(tag, ehi, elo);
  endtask

  initial begin
    int n;
    dec_tab[0]  = '{3'b000, 6'b000000, 4'b0010, 1'b0};
    dec_tab[1]  = '{3'b001, 6'b000000, 4'b0110, 1'b0};
    dec_tab[2]  = '{3'b100, 6'b000000, 4'b0111, 1'b0};
    dec_tab[3]  = '{3'b101, 6'b000000, 4'b0000, 1'b0};
    dec_tab[4]  = '{3'b011, 6'b000000, 4'b0001, 1'b0};
    dec_tab[5]  = '{3'b010, 6'b100000, 4'b0010, 1'b0};
    dec_tab[6]  = '{3'b010, 6'b100010, 4'b0110, 1'b0};
    dec_tab[7]  = '{3'b010, 6'b100100, 4'b0000, 1'b0};
    dec_tab[8]  = '{3'b010, 6'b100101, 4'b0001, 1'b0};
    dec_tab[9]  = '{3'b010, 6'b100111, 4'b1100, 1'b0};
    dec_tab[10] = '{3'b010, 6'b101010, 4'b0111, 1'b0};
    dec_tab[11] = '{3'b010, 6'b010000, 4'b0000, 1'b0};
    dec_tab[12] = '{3'b010, 6'b011011, 4'b0000, 1'b0};
    dec_tab[13] = '{3'b010, 6'b111111, 4'b0000, 1'b1};
    dec_tab[14] = '{3'b010, 6'b000000, 4'b0000, 1'b1};
    dec_tab[15] = '{3'b111, 6'b100111, 4'b0000, 1'b0};
    dec_tab[16] = '{3'b110, 6'b111111, 4'b0000, 1'b0};

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst busy", {63'h0, busy}, 64'h0);
    chk("rst stall", {63'h0, stall}, 64'h0);
    chk("rst md_result", {32'h0, md_result}, 64'h0);
    chk("rst md_sel", {63'h0, md_result_sel}, 64'h0);
    read_hilo("rst", 32'h0, 32'h0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      alu_op     = dec_tab[i].op;
      func_field = dec_tab[i].fn;
      #1;
      chk($sformatf("dec[%0d] code", i), {60'h0, alu_code}, {60'h0, dec_tab[i].exp_code});
      chk($sformatf("dec[%0d] illegal", i), {63'h0, illegal}, {63'h0, dec_tab[i].exp_ill});
    end
    idle_inputs();

    run_md("mult", 6'b011000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_md("multu", 6'b011001, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
    run_md("div", 6'b011010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("divu0", 6'b011011, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF);
    run_md("div0s", 6'b011010, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run_md("divu", 6'b011011, 32'd100, 32'd7, 32'd2, 32'd14);

    // MULT then MFLO held by the pipeline until busy falls
    start_md(6'b011000, 32'h00001234, 32'h00000010);
    present(6'b010010, 32'h0, 32'h0);
    n = 0;
    while (stall && n < 200) begin
      chk("mflo sel_while_stall", {63'h0, md_result_sel}, 64'h0);
      n++;
      @(posedge clk);
      #1;
    end
    chk("mflo stall_cycles", 64'(n), 64'd33);
    chk("mflo after", {32'h0, md_result}, 64'h00012340);
    chk("mflo after_sel", {63'h0, md_result_sel}, 64'h1);
    idle_inputs();

    // non-md instruction during busy
    start_md(6'b011000, 32'd3, 32'd3);
    instr_valid = 1'b1;
    alu_op      = 3'b000;
    #1;
    chk("add_busy code", {60'h0, alu_code}, 64'h2);
    chk("add_busy stall", {63'h0, stall}, 64'h0);
    chk("add_busy busy", {63'h0, busy}, 64'h1);
    idle_inputs();
    wait_busy(n);
    read_hilo("mult3x3", 32'h0, 32'd9);

    // MTHI / MTLO then read back
    start_md(6'b010001, 32'h12345678, 32'h0);
    chk("mthi no_busy", {63'h0, busy}, 64'h0);
    start_md(6'b010011, 32'hCAFEF00D, 32'h0);
    read_hilo("mthi_mtlo", 32'h12345678, 32'hCAFEF00D);

    // MFHI in the start cycle reads the old HI
    @(negedge clk);
    present(6'b011000, 32'd2, 32'd2);
    #1;
    chk("start_cycle_no_stall", {63'h0, stall}, 64'h0);
    idle_inputs();
    alu_op = 3'b010; func_field = 6'b010000; instr_valid = 1'b1;
    #1;
    chk("mfhi old_value", {32'h0, md_result}, 64'h12345678);
    func_field = 6'b011000; operand_a = 32'd2; operand_b = 32'd2;
    @(posedge clk);
    #1;
    idle_inputs();
    wait_busy(n);
    read_hilo("mult2x2", 32'h0, 32'd4);

    // second MULT while busy stalls and is not latched
    start_md(6'b011000, 32'd5, 32'd5);
    present(6'b011000, 32'd100, 32'd100);
    #1;
    chk("mult2 stall", {63'h0, stall}, 64'h1);
    repeat (5) @(posedge clk);
    #1;
    chk("mult2 stall_later", {63'h0, stall}, 64'h1);
    idle_inputs();
    wait_busy(n);
    chk("mult2 done", {63'h0, busy}, 64'h0);
    read_hilo("mult2", 32'h0, 32'd25);

    // reset in mid-operation
    start_md(6'b011000, 32'd5, 32'd5);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    read_hilo("midrst", 32'h0, 32'h0);
    run_md("after_rst", 6'b011000, 32'd6, 32'd7, 32'h0, 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
